// File: rtl/obstacle_collide.sv
// obstacle_collide: consumer end of the jump controller's height/status interface.
// While the game runs, a single ground obstacle scrolls right-to-left across a SCREEN_W-column
// track, one column per scroll step (every TICK_DIV cycles). Every cycle the obstacle column
// and the live dinosaur height are compared; a hit raises a one-cycle crash pulse and freezes
// the track until game_status drops. Cleared obstacles are counted into a saturating score.
//
// Ports:
//   CLK              in   1   system clock, all logic on posedge
//   RST              in   1   synchronous active-high reset
//   game_status      in   1   1 = game running
//   dinosaur_height  in   6   dinosaur height above ground, unsigned
//   obstacle_x       out  6   current obstacle column
//   obstacle_valid   out  1   obstacle on track
//   crash            out  1   one-cycle pulse on collision
//   score            out  10  obstacles cleared this run, saturates at 1023
module obstacle_collide #(
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned SCREEN_W  = 64,
  parameter int unsigned DINO_X    = 8,
  parameter int unsigned OBST_H    = 12,
  parameter int unsigned MIN_GAP   = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       game_status,
  input  logic [5:0] dinosaur_height,
  output logic [5:0] obstacle_x,
  output logic       obstacle_valid,
  output logic       crash,
  output logic [9:0] score
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [5:0] XSpawn = 6'(SCREEN_W - 1);
  localparam logic [5:0] XDino  = 6'(DINO_X);
  localparam logic [6:0] HClear = 7'(OBST_H);
  localparam logic [5:0] GapMin = 6'(MIN_GAP);

  typedef enum logic [1:0] {StIdle, StRun, StCrashed} state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [5:0]       gap_q;
  logic [7:0]       lfsr_q;
  logic [5:0]       x_q;
  logic             valid_q;
  logic             crash_q;
  logic [9:0]       score_q;

  logic hit;
  logic step;
  logic lfsr_fb;

  // Height is compared live against the registered column, so a jump that lands in the
  // same cycle the obstacle arrives is still judged on the current height.
  assign hit     = valid_q && (x_q == XDino) && ({1'b0, dinosaur_height} < HClear);
  assign step    = (tick_q == TickLast);
  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tick_q  <= '0;
      gap_q   <= GapMin;
      lfsr_q  <= LFSR_SEED;
      x_q     <= '0;
      valid_q <= 1'b0;
      crash_q <= 1'b0;
      score_q <= '0;
    end else begin
      crash_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (game_status) begin
            state_q <= StRun;
            score_q <= '0;
            tick_q  <= '0;
            gap_q   <= GapMin;
          end
        end
        StRun: begin
          if (hit) begin
            // A hit pre-empts a coincident step: nothing moves, scores or shifts.
            crash_q <= 1'b1;
            state_q <= StCrashed;
          end else if (!game_status) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end else begin
            tick_q <= step ? '0 : tick_q + TickW'(1);
            if (step) begin
              lfsr_q <= {lfsr_q[6:0], lfsr_fb};
              if (valid_q) begin
                if (x_q == 6'd0) begin
                  valid_q <= 1'b0;
                  if (score_q != 10'h3FF) score_q <= score_q + 10'd1;
                end else begin
                  x_q <= x_q - 6'd1;
                end
              end else if (gap_q != 6'd0) begin
                gap_q <= gap_q - 6'd1;
              end else begin
                x_q     <= XSpawn;
                valid_q <= 1'b1;
                gap_q   <= GapMin + {2'b00, lfsr_q[3:0]};
              end
            end
          end
        end
        StCrashed: begin
          // Obstacle stays visible until the run is abandoned.
          if (!game_status) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign obstacle_x     = x_q;
  assign obstacle_valid = valid_q;
  assign crash          = crash_q;
  assign score          = score_q;

endmodule

// File: tb/tb_obstacle_collide.sv
// Bench for obstacle_collide: directed vector table, hand-written crash/boundary/reset
// sequences, randomized run against a reference model, and a score-saturation run on a
// second, faster instance.
module tb_obstacle_collide;

  localparam int TD = 4;
  localparam int SW = 16;
  localparam int DX = 2;
  localparam int OH = 12;
  localparam int MG = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       game_status = 1'b0;
  logic [5:0] dinosaur_height = 6'd0;
  logic [5:0] obstacle_x;
  logic       obstacle_valid;
  logic       crash;
  logic [9:0] score;

  logic       rst2 = 1'b1;
  logic       gs2 = 1'b0;
  logic [5:0] h2 = 6'd63;
  logic [5:0] x2;
  logic       v2;
  logic       c2;
  logic [9:0] s2;

  always #5 CLK = ~CLK;

  obstacle_collide #(
    .TICK_DIV (TD),
    .SCREEN_W (SW),
    .DINO_X   (DX),
    .OBST_H   (OH),
    .MIN_GAP  (MG),
    .LFSR_SEED(8'hA5)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .game_status    (game_status),
    .dinosaur_height(dinosaur_height),
    .obstacle_x     (obstacle_x),
    .obstacle_valid (obstacle_valid),
    .crash          (crash),
    .score          (score)
  );

  // Small, fast instance so 1023+ obstacles fit in a short run.
  obstacle_collide #(
    .TICK_DIV (2),
    .SCREEN_W (4),
    .DINO_X   (0),
    .OBST_H   (12),
    .MIN_GAP  (1),
    .LFSR_SEED(8'hA5)
  ) dut_sat (
    .CLK            (CLK),
    .RST            (rst2),
    .game_status    (gs2),
    .dinosaur_height(h2),
    .obstacle_x     (x2),
    .obstacle_valid (v2),
    .crash          (c2),
    .score          (s2)
  );

  int checks = 0;
  int failures = 0;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) until the obstacle is visible at column target.
  task automatic wait_x(input int target, input int bound, input string name);
    int n = 0;
    while (!(obstacle_valid && int'(obstacle_x) == target) && n < bound) begin
      cyc();
      n++;
    end
    check(name, int'(obstacle_valid && int'(obstacle_x) == target), 1);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 crashed
  int m_mode, m_x, m_valid, m_crash, m_score, m_cyc, m_gap, m_lfsr;

  function automatic int lfsr_next(input int l);
    int taps = l & 8'hB8;  // bits 7,5,4,3
    return ((l << 1) | ($countones(taps) % 2)) & 255;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_valid = 0; m_crash = 0; m_score = 0;
    m_cyc = 0; m_gap = MG; m_lfsr = 8'hA5;
  endtask

  // One clock of the game as described: cycles within a run are counted from the
  // run start and every TD-th one is a scroll step.
  task automatic model_clock(input bit rst, input bit gs, input int h);
    if (rst) begin
      model_reset();
      return;
    end
    m_crash = 0;
    if (m_mode == 0) begin
      m_valid = 0;
      if (gs) begin
        m_mode = 1; m_score = 0; m_cyc = 0; m_gap = MG;
      end
    end else if (m_mode == 1) begin
      if (m_valid == 1 && m_x == DX && h < OH) begin
        m_crash = 1;
        m_mode = 2;
      end else if (!gs) begin
        m_mode = 0;
        m_valid = 0;
      end else begin
        m_cyc++;
        if (m_cyc == TD) begin
          m_cyc = 0;
          if (m_valid == 1) begin
            if (m_x == 0) begin
              m_valid = 0;
              m_score = (m_score < 1023) ? m_score + 1 : 1023;
            end else m_x--;
          end else if (m_gap > 0) m_gap--;
          else begin
            m_x = SW - 1;
            m_valid = 1;
            m_gap = MG + (m_lfsr % 16);
          end
          m_lfsr = lfsr_next(m_lfsr);
        end
      end
    end else begin
      if (!gs) begin
        m_mode = 0;
        m_valid = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit   rst;
    bit   gs;
    int   h;
    int   n;
    int   ex;
    int   ev;
    int   ec;
    int   es;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit r_gs;
    int r_h;
    bit r_rst;
    int clears;
    int n;
    bit prev_v;

    // rst gs h n | x v crash score
    tbl[0]  = '{1'b1, 1'b0, 0,  2,  0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 0,  20, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 20, 1,  0, 0, 0, 0};   // enter run
    tbl[3]  = '{1'b0, 1'b1, 20, 11, 0, 0, 0, 0};   // two gap steps, no spawn yet
    tbl[4]  = '{1'b0, 1'b1, 20, 1,  15, 1, 0, 0};  // third step spawns
    tbl[5]  = '{1'b0, 1'b1, 20, 60, 0, 1, 0, 0};   // 15 moves, jumped over x=2
    tbl[6]  = '{1'b0, 1'b1, 20, 4,  0, 0, 0, 1};   // retire
    tbl[7]  = '{1'b0, 1'b1, 20, 28, 0, 0, 0, 1};   // gap = 2 + 5 from lfsr 0x95
    tbl[8]  = '{1'b0, 1'b1, 20, 4,  15, 1, 0, 1};
    tbl[9]  = '{1'b0, 1'b1, 0,  52, 2, 1, 0, 1};   // arrives at dino column
    tbl[10] = '{1'b0, 1'b1, 0,  1,  2, 1, 1, 1};   // crash one cycle later
    tbl[11] = '{1'b0, 1'b1, 0,  1,  2, 1, 0, 1};   // single-cycle pulse
    tbl[12] = '{1'b0, 1'b1, 0,  10, 2, 1, 0, 1};   // frozen, no re-trigger
    tbl[13] = '{1'b0, 1'b0, 0,  1,  2, 0, 0, 1};   // back to idle, score held

    for (int i = 0; i < 14; i++) begin
      RST = tbl[i].rst;
      game_status = tbl[i].gs;
      dinosaur_height = 6'(tbl[i].h);
      for (int k = 0; k < tbl[i].n; k++) cyc();
      check($sformatf("vec%0d.x", i), int'(obstacle_x), tbl[i].ex);
      check($sformatf("vec%0d.valid", i), int'(obstacle_valid), tbl[i].ev);
      check($sformatf("vec%0d.crash", i), int'(crash), tbl[i].ec);
      check($sformatf("vec%0d.score", i), int'(score), tbl[i].es);
    end

    // ---- height just below the obstacle: crash ----
    game_status = 1'b1;
    dinosaur_height = 6'd20;
    wait_x(3, 600, "h11.reach3");
    dinosaur_height = 6'd11;
    wait_x(2, 20, "h11.reach2");
    check("h11.no_early_crash", int'(crash), 0);
    cyc();
    check("h11.crash", int'(crash), 1);
    check("h11.x_frozen", int'(obstacle_x), 2);
    cyc();
    check("h11.pulse_end", int'(crash), 0);
    game_status = 1'b0;
    cyc();
    check("h11.idle_valid", int'(obstacle_valid), 0);
    check("h11.score", int'(score), 0);

    // ---- height equal to the obstacle: clears ----
    game_status = 1'b1;
    dinosaur_height = 6'd20;
    wait_x(3, 600, "h12.reach3");
    dinosaur_height = 6'd12;
    wait_x(2, 20, "h12.reach2");
    n = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (crash) n++;
    end
    check("h12.crash_count", n, 0);
    check("h12.x", int'(obstacle_x), 0);
    check("h12.valid", int'(obstacle_valid), 1);

    // ---- reset mid-run ----
    dinosaur_height = 6'd20;
    wait_x(7, 1000, "rst.reach7");
    RST = 1'b1;
    cyc();
    check("rst.x", int'(obstacle_x), 0);
    check("rst.valid", int'(obstacle_valid), 0);
    check("rst.crash", int'(crash), 0);
    check("rst.score", int'(score), 0);
    RST = 1'b0;
    game_status = 1'b0;

    // ---- randomized run against the model (lfsr seed restored by reset) ----
    model_reset();
    r_gs = 1'b1;
    r_h = 20;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) r_gs = !r_gs;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: r_h = 11;
          1: r_h = 12;
          default: r_h = $urandom_range(0, 30);
        endcase
      end
      RST = r_rst;
      game_status = r_gs;
      dinosaur_height = 6'(r_h);
      model_clock(r_rst, r_gs, r_h);
      cyc();
      check($sformatf("rnd%0d.x", i), int'(obstacle_x), m_x);
      check($sformatf("rnd%0d.valid", i), int'(obstacle_valid), m_valid);
      check($sformatf("rnd%0d.crash", i), int'(crash), m_crash);
      check($sformatf("rnd%0d.score", i), int'(score), m_score);
    end
    RST = 1'b0;
    game_status = 1'b0;

    // ---- score saturation on the fast instance ----
    cyc();
    cyc();
    rst2 = 1'b0;
    gs2 = 1'b1;
    clears = 0;
    prev_v = 1'b0;
    n = 0;
    while (clears < 1026 && n < 60000) begin
      cyc();
      n++;
      if (prev_v && !v2) begin
        clears++;
        check($sformatf("sat.clear%0d", clears), int'(s2), (clears < 1023) ? clears : 1023);
      end
      prev_v = v2;
    end
    check("sat.reached", int'(clears >= 1026), 1);
    check("sat.final", int'(s2), 1023);
    check("sat.no_crash", int'(c2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
